// File: rtl/trg_mon_pkg.sv
// trg_mon_pkg: state type and constants shared by the monitor scan block.
// The CKS state exists only when TRG_MON_CKSUM_EN is defined.
package trg_mon_pkg;

    localparam logic [15:0] PAT_5AA5       = 16'h5AA5;
    localparam logic [15:0] PAT_EB90       = 16'hEB90;

    localparam logic [7:0]  DEF_FIRST_ADDR = 8'h02;
    localparam logic [7:0]  DEF_LAST_ADDR  = 8'h22;
    localparam logic [15:0] DEF_FRAME_HDR  = PAT_EB90;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        CNT  = 3'd2,
        RD   = 3'd3,
        CAP  = 3'd4,
        SEND = 3'd5,
`ifdef TRG_MON_CKSUM_EN
        CKS  = 3'd6,
`endif
        DONE = 3'd7
    } state_t;

endpackage

// File: rtl/trg_mon_scan.sv
// trg_mon_scan: reads a monitor address range and streams it as a framed
// word sequence. Define TRG_MON_CKSUM_EN to append a 16-bit checksum word.
module trg_mon_scan
    import trg_mon_pkg::*;
#(
    parameter logic [7:0]  FIRST_ADDR = DEF_FIRST_ADDR,
    parameter logic [7:0]  LAST_ADDR  = DEF_LAST_ADDR,
    parameter logic [15:0] FRAME_HDR  = DEF_FRAME_HDR
) (
    input  logic        clk_in,
    input  logic        rst_in_N,
    input  logic        start_in,
    input  logic [15:0] mon_data_in,
    output logic        rd_out,
    output logic [7:0]  rd_addr_out,
    output logic [15:0] frame_data_out,
    output logic        frame_valid_out,
    input  logic        frame_ready_in,
    output logic        frame_sof_out,
    output logic        frame_eof_out,
    output logic        busy_out,
    output logic [15:0] frame_cnt_out
);

    state_t state;
    logic   xfer;
    logic   at_last;

`ifdef TRG_MON_CKSUM_EN
    logic [15:0] cksum;
`endif

    // A word moves only when the registered valid meets ready.
    assign xfer    = frame_valid_out & frame_ready_in;
    // rd_addr_out doubles as the scan address register.
    assign at_last = (rd_addr_out >= LAST_ADDR);

    // Frame sequencer; every output is a register loaded on state entry.
    always_ff @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) begin
            state           <= IDLE;
            rd_out          <= 1'b0;
            rd_addr_out     <= 8'h00;
            frame_data_out  <= 16'h0000;
            frame_valid_out <= 1'b0;
            frame_sof_out   <= 1'b0;
            frame_eof_out   <= 1'b0;
            busy_out        <= 1'b0;
            frame_cnt_out   <= 16'h0000;
`ifdef TRG_MON_CKSUM_EN
            cksum           <= 16'h0000;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        state           <= HDR;
                        busy_out        <= 1'b1;
                        frame_data_out  <= FRAME_HDR;
                        frame_valid_out <= 1'b1;
                        frame_sof_out   <= 1'b1;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        state          <= CNT;
                        frame_data_out <= frame_cnt_out;
                        frame_sof_out  <= 1'b0;
                    end
                end
                CNT: begin
                    if (xfer) begin
                        state           <= RD;
                        frame_valid_out <= 1'b0;
                        rd_out          <= 1'b1;
                        rd_addr_out     <= FIRST_ADDR;
`ifdef TRG_MON_CKSUM_EN
                        cksum           <= frame_cnt_out;
`endif
                    end
                end
                RD: begin
                    rd_out <= 1'b0;
                    state  <= CAP;
                end
                CAP: begin
                    state           <= SEND;
                    frame_data_out  <= mon_data_in;
                    frame_valid_out <= 1'b1;
`ifdef TRG_MON_CKSUM_EN
                    frame_eof_out   <= 1'b0;
                    cksum           <= cksum + mon_data_in;
`else
                    frame_eof_out   <= at_last;
`endif
                end
                SEND: begin
                    if (xfer) begin
                        if (!at_last) begin
                            state           <= RD;
                            frame_valid_out <= 1'b0;
                            rd_out          <= 1'b1;
                            rd_addr_out     <= rd_addr_out + 8'd1;
                        end else begin
`ifdef TRG_MON_CKSUM_EN
                            state           <= CKS;
                            frame_data_out  <= cksum;
                            frame_valid_out <= 1'b1;
                            frame_eof_out   <= 1'b1;
`else
                            state           <= DONE;
                            frame_valid_out <= 1'b0;
                            frame_eof_out   <= 1'b0;
`endif
                        end
                    end
                end
`ifdef TRG_MON_CKSUM_EN
                CKS: begin
                    if (xfer) begin
                        state           <= DONE;
                        frame_valid_out <= 1'b0;
                        frame_eof_out   <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    state         <= IDLE;
                    busy_out      <= 1'b0;
                    frame_cnt_out <= frame_cnt_out + 16'd1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/trg_mon_scan.md
TRG_MON_SCAN -- requirements
Module: trg_mon_scan

Interface
REQ-001 The block SHALL have the parameter FIRST_ADDR, default 8'h02, meaning the first monitor address read in each frame.
REQ-002 The block SHALL have the parameter LAST_ADDR, default 8'h22, meaning the last monitor address read (inclusive); LAST_ADDR >= FIRST_ADDR.
REQ-003 The block SHALL have the parameter FRAME_HDR, default 16'hEB90, meaning the frame header word.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk_in  input  1  system clock (50 MHz)
- rst_in_N  input  1  asynchronous active-low reset
- start_in  input  1  frame request pulse
- mon_data_in  input  16  monitor read data; valid the cycle after rd_out
- rd_out  output  1  monitor read strobe
- rd_addr_out  output  8  monitor read address
- frame_data_out  output  16  frame word
- frame_valid_out  output  1  frame word valid
- frame_ready_in  input  1  downstream accept
- frame_sof_out  output  1  marks the header word
- frame_eof_out  output  1  marks the last word of the frame
- busy_out  output  1  frame in progress
- frame_cnt_out  output  16  count of completed frames

Function
REQ-005 FSM states SHALL be IDLE, HDR, CNT, RD, CAP, SEND, CKS and DONE.
REQ-006 In IDLE with start_in=1: go to HDR and set busy_out=1 next cycle; start_in outside IDLE SHALL be ignored, not queued.
REQ-007 HDR SHALL present FRAME_HDR with sof=1.
REQ-008 CNT SHALL present frame_cnt_out.
REQ-009 RD SHALL assert rd_out=1 with rd_addr_out=current address for exactly one cycle, then go to CAP.
REQ-010 CAP SHALL register mon_data_in into frame_data_out, assert frame_valid_out from the next cycle, and go to SEND.
REQ-011 Every presented word SHALL hold data, valid, sof and eof stable until a cycle with frame_valid_out & frame_ready_in, and the transfer SHALL occur only in that cycle.
REQ-012 frame_valid_out SHALL be driven from a register, with no combinational path from frame_ready_in.
REQ-013 After a SEND transfer: address < LAST_ADDR -> increment the address and go to RD; else go to CKS (macro defined) or DONE.
REQ-014 Minimum cost per data word SHALL be 3 cycles; the next rd_out SHALL be issued no earlier than the cycle after the transfer.
REQ-015 rd_out SHALL be 0 in every state except RD, and rd_addr_out SHALL hold its last value when rd_out=0.
REQ-016 Frame length SHALL be 2 + (LAST_ADDR-FIRST_ADDR+1) words, +1 with the checksum; at defaults this is 35 words (36 with checksum).
REQ-017 eof SHALL be 1 only on the final word of the frame.
REQ-018 DONE SHALL increment frame_cnt_out (wrapping 16'hFFFF -> 16'h0000), clear busy_out and return to IDLE in one cycle; the count value sent in CNT is the pre-increment value.
REQ-019 frame_ready_in held low SHALL stall indefinitely with no data loss and no additional rd_out.

Reset
REQ-020 rst_in_N=0 SHALL, at any time including mid-frame, immediately force IDLE and drive all outputs to 0 (rd_addr_out=0, frame_cnt_out=0); a partial frame is abandoned with no eof.
REQ-021 After reset release, the first frame SHALL start only on a new start_in.

Configuration
REQ-022 With TRG_MON_CKSUM_EN defined: the CKS state SHALL present one extra word = sum mod 2^16 of the count word and all data words (header excluded), with eof=1 on that word.
REQ-023 Without TRG_MON_CKSUM_EN: there SHALL be no CKS state and no adder, and eof=1 on the LAST_ADDR data word.

Structure
REQ-024 Shared package trg_mon_pkg SHALL hold the FSM state typedef, the default FIRST_ADDR/LAST_ADDR/FRAME_HDR constants, and the backup pattern constants 16'h5AA5/16'hEB90.
REQ-025 The block SHALL be implemented as a single module with no sub-module.

Verification
REQ-026 Bench model of the monitor responder: one-cycle registered read latency; data = {8'hA0, addr}, except addr 8'h23 -> 16'h5AA5.
REQ-027 start pulse, ready=1 -> 35 words: EB90(sof), 0000, A002..A022 (eof on A022); rd_out pulses for addresses 02..22 in order; frame_cnt_out = 1 afterwards.
REQ-028 With TRG_MON_CKSUM_EN, same stimulus -> 36th word = sum(0000, A002..A022) mod 2^16 with eof=1; second frame count word = 0001.
REQ-029 ready toggling randomly, with 20-cycle low stalls -> identical word sequence, no duplicate or missing rd_out, data stable while stalled.
REQ-030 start pulse repeated mid-frame -> ignored; exactly one frame produced.
REQ-031 Reset asserted at word 10 -> outputs 0 immediately; after release and a new start, the frame restarts at EB90 with count 0000.
REQ-032 Preload frame_cnt_out to FFFF by running 65535 frames (or force) -> next count word FFFF, then frame_cnt_out = 0000.
